core: RTL and testbench
=======================

# core

Single-cycle 32-bit MIPS-subset processor core. Each clock it fetches one instruction from an external instruction memory, executes it, and commits register, PC and data-memory side effects on the rising edge. It reports a per-instruction status code. It sits between the instruction memory (`InstructionMemory`) and a data memory, both external to this block.

## Interface
- No parameters.
- `i_clk` — input, 1 — clock; all state updates on the rising edge.
- `i_rst` — input, 1 — reset, synchronous and active-high.
- `o_i_addr` — output, 32 — instruction byte address (current PC).
- `i_i_inst` — input, 32 — instruction word at `o_i_addr`, combinational, same cycle.
- `o_d_wen` — output, 1 — data-memory write enable (store).
- `o_d_addr` — output, 32 — data-memory byte address.
- `o_d_wdata` — output, 32 — store data.
- `i_d_rdata` — input, 32 — load data at `o_d_addr`, combinational, same cycle.
- `o_status` — output, 2 — status of the instruction retiring this cycle.
- `o_status_valid` — output, 1 — `o_status` is meaningful this cycle.

## Operation
- Supported R-type instructions (opcode 0x00):
  - add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A (signed).
  - sll 0x00 and srl 0x02, both using shamt.
  - jr 0x08.
- Supported I-type instructions: addi 0x08, lw 0x23, sw 0x2B, beq 0x04, bne 0x05.
- Supported J-type instructions: j 0x02, jal 0x03 (writes PC+4 to $31).
- End marker: the instruction word 0xFFFFFFFF.
- Register file: 32×32 bits. $0 always reads 0; writes to $0 are discarded. Two combinational read ports, one synchronous write port.
- Immediates:
  - addi, lw and sw sign-extend imm16.
  - Branch target = PC+4 + (sext(imm16)<<2).
  - Jump target = {PC+4[31:28], target26, 2'b00}.
- Load/store address: `o_d_addr` = rs + sext(imm16), word-aligned by software; no alignment check.
- `o_d_wen`:
  - High only during a sw cycle, with `o_d_wdata` = rt.
  - Otherwise `o_d_wen` = 0 and `o_d_wdata` = 0.
  - `o_d_addr` is 0 when not executing lw or sw.
- Status encoding (`core_pkg`): R_TYPE = 0, I_TYPE = 1, MIPS_OVERFLOW = 2, MIPS_END = 3.
  - Opcode 0 → R_TYPE.
  - All other legal opcodes, including j and jal → I_TYPE.
- Unknown opcode or funct: treated as a no-op (PC+4, no writes) and reported as I_TYPE.
- End marker:
  - `o_status` = MIPS_END with valid = 1 for one cycle.
  - The core then enters HALT: PC frozen, no writes, `o_status_valid` = 0 permanently until reset.
- States: RUN and HALT.
  - RUN → HALT on the end marker, or on overflow when trapping is enabled.
  - HALT → RUN only via reset.

## Timing
- Reset (`i_rst` = 1 at a rising edge):
  - PC = 0, all registers = 0, state = RUN.
  - While `i_rst` is high: `o_d_wen` = 0 and `o_status_valid` = 0. `o_i_addr` shows the current PC, which is 0 from the edge after reset.
- Latency: one instruction per cycle; CPI = 1.
- Within a cycle, outputs settle combinationally from PC, `i_i_inst` and `i_d_rdata`. Register file, PC and state commit on the next rising edge.
- `o_status_valid` is high in every RUN cycle when reset is not asserted. It describes the instruction at `o_i_addr` in that same cycle.
- Reset asserted mid-program: takes effect at the next edge and cancels the writes of that cycle's instruction.
- PC wraps modulo 2^32.
- A branch or jump to its own address is legal and loops.

## Configuration
- `CORE_OVERFLOW_TRAP_EN` defined:
  - Signed overflow on add, sub or addi suppresses the register write.
  - `o_status` = MIPS_OVERFLOW for that cycle, then the core enters HALT.
- `CORE_OVERFLOW_TRAP_EN` undefined:
  - Results wrap modulo 2^32 and are written.
  - Status is the normal R_TYPE or I_TYPE.
  - MIPS_OVERFLOW is never produced.

## Structure
- `core_pkg` holds:
  - opcode and funct localparams;
  - the status enum (R_TYPE, I_TYPE, MIPS_OVERFLOW, MIPS_END);
  - the end-marker constant 0xFFFFFFFF;
  - the RUN/HALT state enum.
- One sub-module: `core_regfile` (32×32, two read ports, one write port, $0 hardwired, synchronous active-high reset clears all registers).
- Decode, ALU, next-PC logic and status logic stay inline in `core`.

## Test plan
- Reset then first instruction:
  - `i_rst` high for 2 cycles → `o_i_addr` = 0, `o_status_valid` = 0.
  - After release, addi $1,$0,5 → valid = 1, status = 1; next cycle `o_i_addr` = 4 and $1 = 5.
- Arithmetic and memory:
  - add $2,$1,$1 → $2 = 10, status 0.
  - sw $2,8($0) → `o_d_wen` = 1, `o_d_addr` = 8, `o_d_wdata` = 10.
  - lw $3,8($0) with `i_d_rdata` = 10 → $3 = 10.
- Branching:
  - beq $1,$1,-1 at PC 0x10 → next PC 0x10.
  - bne $1,$1,3 → next PC 0x14.
  - jal 0x40 at PC 0x18 → PC 0x100, $31 = 0x1C.
  - jr $31 → PC 0x1C.
- Overflow, with `CORE_OVERFLOW_TRAP_EN` defined:
  - $4 = 0x7FFFFFFF, then addi $5,$4,1 → status 2, $5 unchanged, core halts.
  - With the macro undefined, the same sequence gives $5 = 0x80000000 and status 1.
- End marker: 0xFFFFFFFF → status 3, valid for 1 cycle; afterwards `o_i_addr` constant and valid = 0 until reset.
- $0 protection: add $0,$1,$1 → $0 still reads 0.

Source files
------------

// File: rtl/core_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : core_pkg                                                     |
// | Purpose  : Shared constants and types for the single-cycle MIPS core:   |
// |            opcode/funct codes, status and state enums, end marker and   |
// |            signed-overflow helpers.                                     |
// | Revision : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
package core_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  localparam logic [31:0] C_END_MARKER = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    R_TYPE        = 2'd0,
    I_TYPE        = 2'd1,
    MIPS_OVERFLOW = 2'd2,
    MIPS_END      = 2'd3
  } status_e;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  // Signed overflow of a + b = r: operands agree in sign, result does not.
  function automatic logic add_ovf(input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] r);
    return (a[31] == b[31]) && (r[31] != a[31]);
  endfunction

  // Signed overflow of a - b = r: operands differ in sign, result flips from a.
  function automatic logic sub_ovf(input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] r);
    return (a[31] != b[31]) && (r[31] != a[31]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/core_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : core_if                                                      |
// | Purpose  : Memory/status bus between the core and its environment.      |
// |            Names are from the core's point of view.                     |
// |   o_i_addr/i_i_inst           instruction fetch (combinational)        |
// |   o_d_wen/o_d_addr/o_d_wdata  data-memory store/address                |
// |   i_d_rdata                   load data (combinational)                |
// |   o_status/o_status_valid     per-instruction status                   |
// | Modports : master (core side), slave (memory/environment side)          |
// | Revision : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
interface core_if;
  import core_pkg::*;

  logic [31:0] o_i_addr;
  logic [31:0] i_i_inst;
  logic        o_d_wen;
  logic [31:0] o_d_addr;
  logic [31:0] o_d_wdata;
  logic [31:0] i_d_rdata;
  status_e     o_status;
  logic        o_status_valid;

  modport master (
    output o_i_addr, o_d_wen, o_d_addr, o_d_wdata, o_status, o_status_valid,
    input  i_i_inst, i_d_rdata
  );

  modport slave (
    input  o_i_addr, o_d_wen, o_d_addr, o_d_wdata, o_status, o_status_valid,
    output i_i_inst, i_d_rdata
  );

endinterface
`default_nettype wire

// File: rtl/core_regfile.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : core_regfile                                                 |
// | Purpose  : 32 x 32-bit register file, two combinational read ports and  |
// |            one synchronous write port. $0 reads 0, writes to it dropped.|
// |            Synchronous active-high reset clears every register.         |
// | Ports    : i_clk, i_rst, i_raddr_a/o_rdata_a, i_raddr_b/o_rdata_b,      |
// |            i_wen, i_waddr, i_wdata                                      |
// | Revision : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module core_regfile (
  input  wire logic        i_clk,
  input  wire logic        i_rst,
  input  wire logic [4:0]  i_raddr_a,
  output logic      [31:0] o_rdata_a,
  input  wire logic [4:0]  i_raddr_b,
  output logic      [31:0] o_rdata_b,
  input  wire logic        i_wen,
  input  wire logic [4:0]  i_waddr,
  input  wire logic [31:0] i_wdata
);

  logic [31:0] r_regs [32];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (i_wen && (i_waddr != 5'd0)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = (i_raddr_a == 5'd0) ? 32'd0 : r_regs[i_raddr_a];
  assign o_rdata_b = (i_raddr_b == 5'd0) ? 32'd0 : r_regs[i_raddr_b];

endmodule
`default_nettype wire

// File: rtl/core.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : core                                                         |
// | Purpose  : Single-cycle 32-bit MIPS-subset core. Fetch, decode, execute |
// |            and commit one instruction per clock; RUN/HALT control.      |
// | Ports    : i_clk, i_rst (sync, active-high), bus (core_if.master)       |
// | Config   : CORE_OVERFLOW_TRAP_EN - signed overflow on add/sub/addi      |
// |            drops the write, reports MIPS_OVERFLOW and halts.            |
// | Revision : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module core
  import core_pkg::*;
(
  input  wire logic i_clk,
  input  wire logic i_rst,
  core_if.master    bus
);

  logic [31:0] r_pc;
  state_e      r_state;

  logic [31:0] w_inst;
  logic [5:0]  w_op, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd, w_shamt;
  logic [31:0] w_sext, w_pc_plus4, w_rs_val, w_rt_val;
  logic [31:0] w_add, w_sub, w_addi;

  logic [31:0] w_next_pc;
  state_e      w_next_state;
  logic        w_rf_wen;
  logic [4:0]  w_rf_waddr;
  logic [31:0] w_rf_wdata;
  logic        w_d_wen;
  logic [31:0] w_d_addr, w_d_wdata;
  status_e     w_status;
`ifdef CORE_OVERFLOW_TRAP_EN
  logic        w_trap;
`endif

  assign w_inst     = bus.i_i_inst;
  assign w_op       = w_inst[31:26];
  assign w_rs       = w_inst[25:21];
  assign w_rt       = w_inst[20:16];
  assign w_rd       = w_inst[15:11];
  assign w_shamt    = w_inst[10:6];
  assign w_funct    = w_inst[5:0];
  assign w_sext     = {{16{w_inst[15]}}, w_inst[15:0]};
  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_add      = w_rs_val + w_rt_val;
  assign w_sub      = w_rs_val - w_rt_val;
  assign w_addi     = w_rs_val + w_sext;

  core_regfile u_regfile (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_raddr_a (w_rs),
    .o_rdata_a (w_rs_val),
    .i_raddr_b (w_rt),
    .o_rdata_b (w_rt_val),
    .i_wen     (w_rf_wen),
    .i_waddr   (w_rf_waddr),
    .i_wdata   (w_rf_wdata)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc    <= '0;
      r_state <= ST_RUN;
    end else begin
      r_pc    <= w_next_pc;
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_pc    = r_pc;
    w_next_state = r_state;
    w_rf_wen     = 1'b0;
    w_rf_waddr   = w_rd;
    w_rf_wdata   = '0;
    w_d_wen      = 1'b0;
    w_d_addr     = '0;
    w_d_wdata    = '0;
    w_status     = I_TYPE;
`ifdef CORE_OVERFLOW_TRAP_EN
    w_trap       = 1'b0;
`endif

    if (r_state == ST_RUN) begin
      w_next_pc = w_pc_plus4;
      if (w_inst == C_END_MARKER) begin
        w_status     = MIPS_END;
        w_next_pc    = r_pc;
        w_next_state = ST_HALT;
      end else begin
        case (w_op)
          OP_RTYPE: begin
            w_status = R_TYPE;
            case (w_funct)
              FN_ADD: begin
                w_rf_wen   = 1'b1;
                w_rf_wdata = w_add;
`ifdef CORE_OVERFLOW_TRAP_EN
                w_trap     = add_ovf(w_rs_val, w_rt_val, w_add);
`endif
              end
              FN_SUB: begin
                w_rf_wen   = 1'b1;
                w_rf_wdata = w_sub;
`ifdef CORE_OVERFLOW_TRAP_EN
                w_trap     = sub_ovf(w_rs_val, w_rt_val, w_sub);
`endif
              end
              FN_AND: begin w_rf_wen = 1'b1; w_rf_wdata = w_rs_val & w_rt_val; end
              FN_OR:  begin w_rf_wen = 1'b1; w_rf_wdata = w_rs_val | w_rt_val; end
              FN_SLT: begin
                w_rf_wen   = 1'b1;
                w_rf_wdata = {31'd0, $signed(w_rs_val) < $signed(w_rt_val)};
              end
              FN_SLL: begin w_rf_wen = 1'b1; w_rf_wdata = w_rt_val << w_shamt; end
              FN_SRL: begin w_rf_wen = 1'b1; w_rf_wdata = w_rt_val >> w_shamt; end
              FN_JR:  w_next_pc = w_rs_val;
              default: w_status = I_TYPE;  // unknown funct: no-op
            endcase
          end
          OP_ADDI: begin
            w_rf_wen   = 1'b1;
            w_rf_waddr = w_rt;
            w_rf_wdata = w_addi;
`ifdef CORE_OVERFLOW_TRAP_EN
            w_trap     = add_ovf(w_rs_val, w_sext, w_addi);
`endif
          end
          OP_LW: begin
            w_d_addr   = w_addi;
            w_rf_wen   = 1'b1;
            w_rf_waddr = w_rt;
            w_rf_wdata = bus.i_d_rdata;
          end
          OP_SW: begin
            w_d_addr  = w_addi;
            w_d_wen   = 1'b1;
            w_d_wdata = w_rt_val;
          end
          OP_BEQ: if (w_rs_val == w_rt_val) w_next_pc = w_pc_plus4 + {w_sext[29:0], 2'b00};
          OP_BNE: if (w_rs_val != w_rt_val) w_next_pc = w_pc_plus4 + {w_sext[29:0], 2'b00};
          OP_J:   w_next_pc = {w_pc_plus4[31:28], w_inst[25:0], 2'b00};
          OP_JAL: begin
            w_next_pc  = {w_pc_plus4[31:28], w_inst[25:0], 2'b00};
            w_rf_wen   = 1'b1;
            w_rf_waddr = 5'd31;
            w_rf_wdata = w_pc_plus4;
          end
          default: ;  // unknown opcode: no-op, reported as I_TYPE
        endcase
`ifdef CORE_OVERFLOW_TRAP_EN
        if (w_trap) begin
          w_rf_wen     = 1'b0;
          w_status     = MIPS_OVERFLOW;
          w_next_pc    = r_pc;
          w_next_state = ST_HALT;
        end
`endif
      end
    end
  end

  assign bus.o_i_addr       = r_pc;
  assign bus.o_d_wen        = w_d_wen && !i_rst;
  assign bus.o_d_addr       = w_d_addr;
  assign bus.o_d_wdata      = w_d_wdata;
  assign bus.o_status       = w_status;
  assign bus.o_status_valid = (r_state == ST_RUN) && !i_rst;

endmodule
`default_nettype wire

// File: tb/tb_core.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_core                                                      |
// | Purpose  : Self-checking bench for core. Each driven instruction pushes |
// |            its expected bus outputs to a queue; they are popped and     |
// |            compared on the falling edge of the same cycle.              |
// | Revision : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module tb_core;
  import core_pkg::*;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  core_if u_bus ();

  core u_dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (u_bus.master)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] pc;
    logic        valid;
    logic [1:0]  status;
    logic        wen;
    logic [31:0] daddr;
    logic [31:0] wdata;
  } exp_t;

  exp_t        r_sb[$];
  int          r_errors = 0;
  int          r_checks = 0;
  logic [31:0] r_exp_pc = 32'd0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    r_checks++;
    if (act !== exp) begin
      r_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] r_ins(input int rs, input int rt, input int rd,
                                        input int sh, input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input int rs, input int rt,
                                        input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  // Drive one instruction, queue its expected outputs, compare at negedge,
  // then advance one clock. next_pc becomes the expected address next time.
  task automatic run(input logic [31:0] inst, input logic [31:0] rdata, input logic valid,
                     input logic [1:0] st, input logic wen, input logic [31:0] daddr,
                     input logic [31:0] wdata, input logic [31:0] next_pc);
    exp_t e;
    u_bus.i_i_inst  = inst;
    u_bus.i_d_rdata = rdata;
    e = '{pc: r_exp_pc, valid: valid, status: st, wen: wen, daddr: daddr, wdata: wdata};
    r_sb.push_back(e);
    @(negedge i_clk);
    if (r_sb.size() == 0) begin
      check_val("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = r_sb.pop_front();
      check_val("pc", u_bus.o_i_addr, e.pc);
      check_val("valid", 32'(u_bus.o_status_valid), 32'(e.valid));
      if (e.valid) check_val("status", 32'(u_bus.o_status), 32'(e.status));
      check_val("d_wen", 32'(u_bus.o_d_wen), 32'(e.wen));
      check_val("d_addr", u_bus.o_d_addr, e.daddr);
      check_val("d_wdata", u_bus.o_d_wdata, e.wdata);
    end
    r_exp_pc = next_pc;
    @(posedge i_clk);
    #1;
  endtask

  // Store register r to address 0 to expose its value on o_d_wdata.
  task automatic expect_reg(input int r, input logic [31:0] val);
    run(i_ins(OP_SW, 0, r, 16'h0000), 32'd0, 1'b1, 2'd1, 1'b1, 32'd0, val, r_exp_pc + 32'd4);
  endtask

  localparam logic [31:0] C_SW_PROBE = 32'hAC02_0008;  // sw $2,8($0)

  initial begin
    int          regs_tab [6];
    logic [31:0] vals_tab [6];
    regs_tab = '{6, 7, 8, 9, 10, 11};
    vals_tab = '{32'hFFFF_FFFB, 32'd1, 32'd10, 32'd15, 32'd80, 32'd15};

    // Reset for two cycles with a store on the bus: nothing may leak out.
    u_bus.i_i_inst  = C_SW_PROBE;
    u_bus.i_d_rdata = 32'd0;
    i_rst = 1'b1;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    check_val("rst_pc", u_bus.o_i_addr, 32'd0);
    check_val("rst_valid", 32'(u_bus.o_status_valid), 32'd0);
    check_val("rst_wen", 32'(u_bus.o_d_wen), 32'd0);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;

    run(i_ins(OP_ADDI, 0, 1, 16'd5), 0, 1, 1, 0, 0, 0, 32'h04);        // addi $1,$0,5
    run(r_ins(1, 1, 2, 0, FN_ADD), 0, 1, 0, 0, 0, 0, 32'h08);          // add $2,$1,$1
    run(i_ins(OP_SW, 0, 2, 16'd8), 0, 1, 1, 1, 32'd8, 32'd10, 32'h0C); // sw $2,8($0)
    run(i_ins(OP_LW, 0, 3, 16'd8), 32'd10, 1, 1, 0, 32'd8, 0, 32'h10); // lw $3,8($0)
    run(i_ins(OP_BEQ, 1, 1, 16'hFFFF), 0, 1, 1, 0, 0, 0, 32'h10);      // beq self-loop
    run(i_ins(OP_BNE, 1, 1, 16'd3), 0, 1, 1, 0, 0, 0, 32'h14);         // bne not taken
    run(i_ins(OP_SW, 0, 3, 16'd12), 0, 1, 1, 1, 32'd12, 32'd10, 32'h18);
    run({OP_JAL, 26'h40}, 0, 1, 1, 0, 0, 0, 32'h100);                  // jal 0x40
    run(i_ins(OP_SW, 0, 31, 16'd0), 0, 1, 1, 1, 0, 32'h1C, 32'h104);   // $31 = 0x1C
    run(r_ins(31, 0, 0, 0, FN_JR), 0, 1, 0, 0, 0, 0, 32'h1C);          // jr $31
    run(r_ins(1, 1, 0, 0, FN_ADD), 0, 1, 0, 0, 0, 0, 32'h20);          // add $0,$1,$1
    run(i_ins(OP_SW, 0, 0, 16'd4), 0, 1, 1, 1, 32'd4, 32'd0, 32'h24);  // $0 still 0
    run(r_ins(1, 2, 6, 0, FN_SUB), 0, 1, 0, 0, 0, 0, 32'h28);          // $6 = -5
    run(r_ins(6, 1, 7, 0, FN_SLT), 0, 1, 0, 0, 0, 0, 32'h2C);          // $7 = 1
    run(r_ins(2, 6, 8, 0, FN_AND), 0, 1, 0, 0, 0, 0, 32'h30);          // $8 = 10
    run(r_ins(1, 2, 9, 0, FN_OR), 0, 1, 0, 0, 0, 0, 32'h34);           // $9 = 15
    run(r_ins(0, 1, 10, 4, FN_SLL), 0, 1, 0, 0, 0, 0, 32'h38);         // $10 = 80
    run(r_ins(0, 6, 11, 28, FN_SRL), 0, 1, 0, 0, 0, 0, 32'h3C);        // $11 = 0xF
    for (int i = 0; i < 6; i++) expect_reg(regs_tab[i], vals_tab[i]);
    run(32'hFC00_0000, 0, 1, 1, 0, 0, 0, r_exp_pc + 4);                // unknown opcode
    run(r_ins(1, 1, 12, 0, 6'h3F), 0, 1, 1, 0, 0, 0, r_exp_pc + 4);    // unknown funct
    expect_reg(12, 32'd0);
    run(i_ins(OP_ADDI, 0, 4, 16'hFFFF), 0, 1, 1, 0, 0, 0, r_exp_pc + 4);
    run(r_ins(0, 4, 4, 1, FN_SRL), 0, 1, 0, 0, 0, 0, r_exp_pc + 4);    // $4 = 0x7FFFFFFF
    expect_reg(4, 32'h7FFF_FFFF);
`ifdef CORE_OVERFLOW_TRAP_EN
    run(i_ins(OP_ADDI, 4, 5, 16'd1), 0, 1, 2, 0, 0, 0, r_exp_pc);      // trap, halt
    repeat (3) run(C_SW_PROBE, 0, 0, 0, 0, 0, 0, r_exp_pc);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    r_exp_pc = 32'd0;
    expect_reg(5, 32'd0);                                              // $5 cleared by reset
`else
    run(i_ins(OP_ADDI, 4, 5, 16'd1), 0, 1, 1, 0, 0, 0, r_exp_pc + 4);  // wraps
    expect_reg(5, 32'h8000_0000);
`endif
    run(C_END_MARKER, 0, 1, 3, 0, 0, 0, r_exp_pc);                     // end marker
    repeat (3) run(C_SW_PROBE, 0, 0, 0, 0, 0, 0, r_exp_pc);            // halted

    // Reset leaves HALT; registers are cleared.
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    r_exp_pc = 32'd0;
    expect_reg(1, 32'd0);
    run(i_ins(OP_ADDI, 0, 1, 16'd7), 0, 1, 1, 0, 0, 0, 32'h08);
    expect_reg(1, 32'd7);

    if (r_sb.size() != 0) check_val("scoreboard_leftover", 32'(r_sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", r_errors, r_checks);
    $finish;
  end

endmodule
`default_nettype wire
